// File: rtl/dcache_ctrl_pkg.sv
// Shared types and helpers for the data cache controller and its storage array.
package dcache_ctrl_pkg;

  localparam int DATA_W   = 32;
  localparam int OFFSET_W = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] value);
    return (&value) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// Tag/valid/data storage for a direct-mapped cache: one combinational read port
// and one synchronous write port; only the valid bits are reset.
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES          = 256,
  parameter int WORDS_PER_LINE = 4,
  parameter int TAG_W          = 20,
  parameter int INDEX_W        = $clog2(LINES),
  parameter int WORD_W         = $clog2(WORDS_PER_LINE)
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic [INDEX_W-1:0] rd_index,
  input  logic [WORD_W-1:0]  rd_word,
  output logic [DATA_W-1:0]  rd_data,
  output logic [TAG_W-1:0]   rd_tag,
  output logic               rd_valid,
  input  logic [INDEX_W-1:0] wr_index,
  input  logic               wr_en,
  input  logic [WORD_W-1:0]  wr_word,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               tag_we,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic               valid_set,
  input  logic               valid_clr
);

  logic [DATA_W-1:0] data_mem [LINES][WORDS_PER_LINE];
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [LINES-1:0]  valid_q;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      valid_q <= '0;
    end else if (valid_clr) begin
      valid_q[wr_index] <= 1'b0;
    end else if (valid_set) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      data_mem[wr_index][wr_word] <= wr_data;
    end
    if (tag_we) begin
      tag_mem[wr_index] <= wr_tag;
    end
  end

  assign rd_data  = data_mem[rd_index][rd_word];
  assign rd_tag   = tag_mem[rd_index];
  assign rd_valid = valid_q[rd_index];

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data cache controller.
// Optional hit/miss counters are built when DCACHE_STATS_EN is defined.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int LINES          = 256,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_done,
  output logic              busy,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int WORD_W  = $clog2(WORDS_PER_LINE);
  localparam int INDEX_W = $clog2(LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - WORD_W - OFFSET_W;

  state_t state, next_state;

  logic [WORD_W-1:0]  cpu_word;
  logic [INDEX_W-1:0] cpu_index;
  logic [TAG_W-1:0]   cpu_tag;
  logic               unused_offset;

  logic [TAG_W-1:0]   lat_tag;
  logic [INDEX_W-1:0] lat_index;
  logic [WORD_W-1:0]  lat_word;
  logic [31:0]        lat_wdata;
  logic               lat_hit;
  logic [WORD_W-1:0]  cnt;

  logic [INDEX_W-1:0] rd_index;
  logic [WORD_W-1:0]  rd_word;
  logic [31:0]        rd_data;
  logic [TAG_W-1:0]   rd_tag;
  logic               rd_valid;
  logic               wr_en;
  logic [WORD_W-1:0]  wr_word;
  logic [31:0]        wr_data;
  logic               tag_we;
  logic               valid_set;
  logic               valid_clr;

  logic hit;
  logic accept;
  logic load_hit;

  assign cpu_word      = cpu_addr[OFFSET_W +: WORD_W];
  assign cpu_index     = cpu_addr[OFFSET_W + WORD_W +: INDEX_W];
  assign cpu_tag       = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_offset = ^cpu_addr[OFFSET_W-1:0];

  // In IDLE the array is probed with the live CPU address; afterwards with the latched one.
  assign rd_index = (state == IDLE) ? cpu_index : lat_index;
  assign rd_word  = (state == IDLE) ? cpu_word  : lat_word;

  assign hit      = rd_valid && (rd_tag == cpu_tag);
  assign accept   = (state == IDLE) && cpu_req;
  assign load_hit = accept && !cpu_we && hit;

  dcache_array #(
    .LINES          (LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE),
    .TAG_W          (TAG_W),
    .INDEX_W        (INDEX_W),
    .WORD_W         (WORD_W)
  ) u_array (
    .clock     (clock),
    .resetn    (resetn),
    .rd_index  (rd_index),
    .rd_word   (rd_word),
    .rd_data   (rd_data),
    .rd_tag    (rd_tag),
    .rd_valid  (rd_valid),
    .wr_index  (rd_index),
    .wr_en     (wr_en),
    .wr_word   (wr_word),
    .wr_data   (wr_data),
    .tag_we    (tag_we),
    .wr_tag    (cpu_tag),
    .valid_set (valid_set),
    .valid_clr (valid_clr)
  );

  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    cpu_done   = 1'b0;
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    wr_en      = 1'b0;
    wr_word    = cnt;
    wr_data    = mem_rdata;
    tag_we     = 1'b0;
    valid_set  = 1'b0;
    valid_clr  = 1'b0;

    case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            busy       = 1'b1;
            next_state = WRITE;
          end else if (hit) begin
            next_state = DONE;
          end else begin
            busy       = 1'b1;
            next_state = REFILL;
            tag_we     = 1'b1;
            valid_clr  = 1'b1;
          end
        end
      end
      REFILL: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_index, cnt, {OFFSET_W{1'b0}}};
        if (mem_ack) begin
          wr_en = 1'b1;
          if (&cnt) begin
            valid_set  = 1'b1;
            next_state = DONE;
          end
        end
      end
      WRITE: begin
        busy      = 1'b1;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {lat_tag, lat_index, lat_word, {OFFSET_W{1'b0}}};
        mem_wdata = lat_wdata;
        wr_word   = lat_word;
        wr_data   = lat_wdata;
        if (mem_ack) begin
          wr_en      = lat_hit;
          next_state = DONE;
        end
      end
      DONE: begin
        cpu_done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // The last refill word may be the requested one, so it is taken straight from mem_rdata.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      lat_tag   <= '0;
      lat_index <= '0;
      lat_word  <= '0;
      lat_wdata <= '0;
      lat_hit   <= 1'b0;
      cnt       <= '0;
      cpu_rdata <= '0;
    end else begin
      if (accept) begin
        lat_tag   <= cpu_tag;
        lat_index <= cpu_index;
        lat_word  <= cpu_word;
        lat_wdata <= cpu_wdata;
        lat_hit   <= hit;
        cnt       <= '0;
      end
      if (load_hit) begin
        cpu_rdata <= rd_data;
      end
      if (state == REFILL && mem_ack) begin
        cnt <= cnt + WORD_W'(1);
        if (&cnt) begin
          cpu_rdata <= (cnt == lat_word) ? mem_rdata : rd_data;
        end
      end
    end
  end

`ifdef DCACHE_STATS_EN
  logic load_miss;
  assign load_miss = accept && !cpu_we && !hit;

  always_ff @(posedge clock) begin
    if (!resetn) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (load_hit) begin
        hit_count <= sat_inc(hit_count);
      end
      if (load_miss) begin
        miss_count <= sat_inc(miss_count);
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: a word-addressed memory responder, a line-level
// cache model and a per-cycle compare process, plus literal expectations.
module tb_dcache_ctrl;

  localparam int LINES = 256;
  localparam int WPL   = 4;
  localparam logic [31:0] LINE_BYTES = 32'(4 * WPL);
  localparam logic [31:0] NLINES     = 32'(LINES);
  localparam logic [31:0] FILL_KEY   = 32'hC0DE0000;

  logic        clock;
  logic        resetn;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        busy;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
`endif

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mem_op_t;

  typedef struct {
    logic        is_load;
    logic [31:0] data;
  } done_t;

  mem_op_t     exp_ops[$];
  done_t       exp_done[$];
  logic [31:0] bench_mem [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  bit          m_valid [LINES];
  logic [31:0] m_tag   [LINES];

  int errors       = 0;
  int checks       = 0;
  int ack_count    = 0;
  int inject_seq   = 0;
  int model_hits   = 0;
  int model_misses = 0;
  bit ack_hold     = 0;

  dcache_ctrl dut (
    .clock      (clock),
    .resetn     (resetn),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_done   (cpu_done),
    .busy       (busy),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] bench_read(input logic [31:0] a);
    return bench_mem.exists(a) ? bench_mem[a] : (a ^ FILL_KEY);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : (a ^ FILL_KEY);
  endfunction

  // Loads always return current memory contents; only the hit/miss decision needs line state.
  function automatic void model_issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    logic [31:0] tag;
    logic [31:0] waddr;
    logic [31:0] base;
    mem_op_t     op;
    done_t       d;
    waddr = addr & ~32'h3;
    idx   = int'((addr / LINE_BYTES) % NLINES);
    tag   = addr / (LINE_BYTES * NLINES);
    if (we) begin
      op.we = 1'b1; op.addr = waddr; op.data = wdata;
      exp_ops.push_back(op);
      ref_mem[waddr] = wdata;
      d.is_load = 1'b0; d.data = '0;
    end else begin
      if (m_valid[idx] && m_tag[idx] == tag) begin
        model_hits++;
      end else begin
        model_misses++;
        base = waddr - (waddr % LINE_BYTES);
        for (int w = 0; w < WPL; w++) begin
          op.we = 1'b0; op.addr = base + 32'(4 * w); op.data = '0;
          exp_ops.push_back(op);
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
      end
      d.is_load = 1'b1; d.data = ref_read(waddr);
    end
    exp_done.push_back(d);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
    exp_ops.delete();
    exp_done.delete();
    model_hits   = 0;
    model_misses = 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
    end
  endtask

  // Memory responder: each word is acknowledged two cycles after mem_req is seen.
  initial begin
    int wait_cnt;
    int seen_seq;
    wait_cnt  = 0;
    seen_seq  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clock);
      if (mem_ack) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (inject_seq != seen_seq) begin
        seen_seq  = inject_seq;
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADBAD00;
      end else if (resetn && mem_req && !ack_hold) begin
        wait_cnt++;
        if (wait_cnt >= 2) begin
          mem_ack = 1'b1;
          if (mem_we) bench_mem[mem_addr] = mem_wdata;
          else        mem_rdata = bench_read(mem_addr);
          ack_count++;
          wait_cnt = 0;
        end
      end
    end
  end

  // Compare process: every acknowledged memory access and every completion against the model.
  initial begin
    mem_op_t op;
    done_t   d;
    forever begin
      @(negedge clock);
      #2;
      if (mem_req && mem_ack) begin
        checkOutput("mem_op_expected", 32'(exp_ops.size() > 0), 32'd1);
        if (exp_ops.size() > 0) begin
          op = exp_ops.pop_front();
          checkOutput("mem_addr", mem_addr, op.addr);
          checkOutput("mem_we", 32'(mem_we), 32'(op.we));
          if (op.we) checkOutput("mem_wdata", mem_wdata, op.data);
        end
      end
      if (cpu_done) begin
        checkOutput("done_busy", 32'(busy), 32'd0);
        checkOutput("done_mem_req", 32'(mem_req), 32'd0);
        checkOutput("done_ops_drained", 32'(exp_ops.size()), 32'd0);
        checkOutput("done_expected", 32'(exp_done.size() > 0), 32'd1);
        if (exp_done.size() > 0) begin
          d = exp_done.pop_front();
          if (d.is_load) checkOutput("model_rdata", cpu_rdata, d.data);
        end
      end
    end
  end

  task automatic applyStimulus(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                               output int cycles, output int ops, output logic req_busy,
                               output logic [31:0] rdata);
    int acks_before;
    acks_before = ack_count;
    @(negedge clock);
    #3;
    cpu_req   = 1'b1;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    model_issue(we, addr, wdata);
    #1;
    req_busy = busy;
    cycles = 0;
    do begin
      @(negedge clock);
      #3;
      cycles++;
    end while (!cpu_done && cycles < 200);
    checkOutput("done_seen", 32'(cpu_done), 32'd1);
    rdata   = cpu_rdata;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    ops     = ack_count - acks_before;
  endtask

  initial begin
    int          cyc;
    int          ops;
    int          n;
    int          base_acks;
    logic        rb;
    logic [31:0] rd;

    resetn    = 1'b0;
    cpu_req   = 1'b0;
    cpu_we    = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    for (int w = 0; w < WPL; w++) begin
      bench_mem[32'h00080000 + 32'(4 * w)] = 32'(17 * (w + 1));
      ref_mem[32'h00080000 + 32'(4 * w)]   = 32'(17 * (w + 1));
    end
    model_reset();

    repeat (3) @(negedge clock);
    #2;
    checkOutput("rst_cpu_done", 32'(cpu_done), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", mem_addr, 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_rdata", cpu_rdata, 32'd0);
    #1 resetn = 1'b1;

    applyStimulus(1'b0, 32'h00080000, '0, cyc, ops, rb, rd);
    checkOutput("miss_ops", 32'(ops), 32'd4);
    checkOutput("miss_busy", 32'(rb), 32'd1);
    checkOutput("miss_rdata", rd, 32'h00000011);

    applyStimulus(1'b0, 32'h00080008, '0, cyc, ops, rb, rd);
    checkOutput("hit_ops", 32'(ops), 32'd0);
    checkOutput("hit_latency", 32'(cyc), 32'd1);
    checkOutput("hit_busy", 32'(rb), 32'd0);
    checkOutput("hit_rdata", rd, 32'h00000033);

    applyStimulus(1'b1, 32'h00080004, 32'hDEADBEEF, cyc, ops, rb, rd);
    checkOutput("st_hit_ops", 32'(ops), 32'd1);
    checkOutput("st_hit_busy", 32'(rb), 32'd1);
    applyStimulus(1'b0, 32'h00080004, '0, cyc, ops, rb, rd);
    checkOutput("st_hit_reload_ops", 32'(ops), 32'd0);
    checkOutput("st_hit_reload_rdata", rd, 32'hDEADBEEF);

    applyStimulus(1'b1, 32'h00090000, 32'h12345678, cyc, ops, rb, rd);
    checkOutput("st_miss_ops", 32'(ops), 32'd1);
    applyStimulus(1'b0, 32'h00090000, '0, cyc, ops, rb, rd);
    checkOutput("st_miss_load_ops", 32'(ops), 32'd4);
    checkOutput("st_miss_load_rdata", rd, 32'h12345678);

    applyStimulus(1'b0, 32'h00080000, '0, cyc, ops, rb, rd);
    checkOutput("evict1_ops", 32'(ops), 32'd4);
    checkOutput("evict1_rdata", rd, 32'h00000011);
    applyStimulus(1'b0, 32'h00081000, '0, cyc, ops, rb, rd);
    checkOutput("alias_ops", 32'(ops), 32'd4);
    checkOutput("alias_rdata", rd, 32'hC0D61000);
    applyStimulus(1'b0, 32'h00080000, '0, cyc, ops, rb, rd);
    checkOutput("evict2_ops", 32'(ops), 32'd4);
    checkOutput("evict2_rdata", rd, 32'h00000011);

    applyStimulus(1'b0, 32'h000A000C, '0, cyc, ops, rb, rd);
    checkOutput("last_word_ops", 32'(ops), 32'd4);
    checkOutput("last_word_rdata", rd, 32'hC0D4000C);

    applyStimulus(1'b0, 32'h00000FF0, '0, cyc, ops, rb, rd);
    checkOutput("top_index_ops", 32'(ops), 32'd4);
    checkOutput("top_index_rdata", rd, 32'hC0DE0FF0);
    applyStimulus(1'b0, 32'h00000FF4, '0, cyc, ops, rb, rd);
    checkOutput("top_index_hit_ops", 32'(ops), 32'd0);
    checkOutput("top_index_hit_rdata", rd, 32'hC0DE0FF4);

    // Abandon a refill after its second word, then prove the line was left invalid.
    base_acks = ack_count;
    @(negedge clock);
    #3;
    cpu_req  = 1'b1;
    cpu_we   = 1'b0;
    cpu_addr = 32'h00080000;
    model_issue(1'b0, 32'h00080000, '0);
    n = 0;
    while (ack_count < base_acks + 2 && n < 200) begin
      @(negedge clock);
      #3;
      n++;
    end
    checkOutput("abort_acks_before_reset", 32'(ack_count - base_acks), 32'd2);
    @(negedge clock);
    #3;
    resetn   = 1'b0;
    cpu_req  = 1'b0;
    ack_hold = 1'b1;
    model_reset();
    @(negedge clock);
    #2;
    checkOutput("abort_mem_req", 32'(mem_req), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_cpu_done", 32'(cpu_done), 32'd0);
    checkOutput("abort_cpu_rdata", cpu_rdata, 32'd0);
    #1;
    resetn = 1'b1;
    inject_seq++;
    @(negedge clock);
    @(negedge clock);
    #2;
    checkOutput("late_ack_cpu_done", 32'(cpu_done), 32'd0);
    checkOutput("late_ack_mem_req", 32'(mem_req), 32'd0);
    checkOutput("late_ack_busy", 32'(busy), 32'd0);
    #1 ack_hold = 1'b0;

    applyStimulus(1'b0, 32'h00080000, '0, cyc, ops, rb, rd);
    checkOutput("post_abort_ops", 32'(ops), 32'd4);
    checkOutput("post_abort_rdata", rd, 32'h00000011);
    applyStimulus(1'b0, 32'h00080008, '0, cyc, ops, rb, rd);
    checkOutput("post_abort_hit_ops", 32'(ops), 32'd0);
    checkOutput("post_abort_hit_rdata", rd, 32'h00000033);

    repeat (2) @(negedge clock);
    #2;
    checkOutput("queues_drained", 32'(exp_ops.size() + exp_done.size()), 32'd0);
    checkOutput("idle_mem_req", 32'(mem_req), 32'd0);
`ifdef DCACHE_STATS_EN
    checkOutput("hit_count", hit_count, 32'(model_hits));
    checkOutput("miss_count", miss_count, 32'(model_misses));
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] timeout");
  end

endmodule
